// File: rtl/mem_access_unit.sv
// Load/store initiator for the single-cycle data memory: one request at a time, registered pins.
// Latency: store ack 1 edge after accept, load response 2 edges after accept (read data registered in memory).
// Backpressure: req_ready only in IDLE; resp_valid is a one-cycle pulse the consumer must take.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR_ISSUE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
  logic [15:0]         rd_count_q, rd_count_d;
  logic [15:0]         wr_count_q, wr_count_d;

  // Next-state and registered-output computation; strobes default low so each lasts one cycle.
  always_comb begin
    state_d          = state_q;
    resp_valid_d     = 1'b0;
    resp_rdata_d     = resp_rdata_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    rd_count_d       = rd_count_q;
    wr_count_d       = wr_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          mem_address_d    = req_addr;
          mem_write_data_d = req_wdata;
          if (req_write) begin
            state_d     = WR_ISSUE;
            mem_write_d = 1'b1;
          end else begin
            state_d    = RD_ISSUE;
            mem_read_d = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        // Memory samples mem_read at the end of this cycle; its data lands next cycle.
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = mem_read_data;
        if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
      end
      WR_ISSUE: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    // Ready is registered, so derive it from where the FSM is going.
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      rd_count_q       <= '0;
      wr_count_q       <= '0;
    end else begin
      state_q          <= state_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      rd_count_q       <= rd_count_d;
      wr_count_q       <= wr_count_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random load/store traffic against a registered-read memory.
// Expected data comes from a word array updated at request acceptance; counters modelled as saturating ints.
// Responses are observed on falling edges and their latency is counted in cycles from the accept edge.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  int          n_cmp;
  int          n_err;
  int          rd_m;
  int          wr_m;

  mem_access_unit #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory stand-in: synchronous write, registered read, contents survive reset.
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
    if (mem_read)  mem_read_data    <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req_ready"},      req_ready, 1);
    chk({pfx, "_resp_valid"},     resp_valid, 0);
    chk({pfx, "_resp_rdata"},     resp_rdata, 0);
    chk({pfx, "_mem_read"},       mem_read, 0);
    chk({pfx, "_mem_write"},      mem_write, 0);
    chk({pfx, "_mem_address"},    mem_address, 0);
    chk({pfx, "_mem_write_data"}, mem_write_data, 0);
    chk({pfx, "_rd_count"},       rd_count, 0);
    chk({pfx, "_wr_count"},       wr_count, 0);
  endtask

  // Issue one request from a falling edge and follow it to its response.
  // Returns on the falling edge inside the response cycle; with hold set, req_valid stays high
  // so the caller can present the next request back-to-back.
  task automatic do_req(input logic w, input logic [7:0] a, input logic [15:0] d, input bit hold);
    int          k;
    int          nrd;
    int          nwr;
    bit          both;
    bit          got;
    logic [15:0] expd;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_seen", req_ready, 1);
    expd = w ? 16'h0000 : ref_mem[a];
    if (w) ref_mem[a] = d;
    @(posedge clk);
    @(negedge clk);
    chk("addr_latched", mem_address, a);
    if (w) chk("wdata_latched", mem_write_data, d);
    chk("busy_not_ready", req_ready, 0);
    chk("resp_low_after_accept", resp_valid, 0);
    nrd = 0;
    nwr = 0;
    both = 1'b0;
    got = 1'b0;
    k = 1;
    while (!got && k <= 8) begin
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (mem_read && mem_write) both = 1'b1;
      if (resp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk("resp_seen", got, 1);
    chk("resp_latency", k, w ? 2 : 3);
    chk("resp_rdata", resp_rdata, expd);
    chk("mem_read_pulses", nrd, w ? 0 : 1);
    chk("mem_write_pulses", nwr, w ? 1 : 0);
    chk("rd_wr_overlap", both, 0);
    chk("ready_with_resp", req_ready, 1);
    if (w) wr_m = (wr_m < 65535) ? wr_m + 1 : wr_m;
    else   rd_m = (rd_m < 65535) ? rd_m + 1 : rd_m;
    chk("rd_count", rd_count, rd_m);
    chk("wr_count", wr_count, wr_m);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rd_m  = 0;
    wr_m  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 1);
    mem[3]   = 16'd123;
    mem[14]  = 16'd34;
    mem[63]  = 16'd123;
    mem[154] = 16'd10;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    mem_read_data = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset values while held in reset.
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load of a preset word.
    do_req(1'b0, 8'd3, 16'h0, 1'b0);
    @(negedge clk);
    chk("resp_single_pulse", resp_valid, 0);

    // Store then immediate load of the same address.
    do_req(1'b1, 8'd10, 16'h1234, 1'b1);
    do_req(1'b0, 8'd10, 16'h0, 1'b0);
    @(negedge clk);

    // Back-to-back with req_valid held high throughout.
    do_req(1'b0, 8'd14, 16'd55, 1'b1);
    do_req(1'b1, 8'd20, 16'd55, 1'b1);
    do_req(1'b0, 8'd63, 16'd55, 1'b1);
    do_req(1'b1, 8'd20, 16'd55, 1'b0);
    @(negedge clk);
    chk("b2b_addr20", ref_mem[20], 16'd55);

    // Asynchronous reset while the load sits in RD_WAIT.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'd154;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_mem_read", mem_read, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_resp", resp_valid, 0);
    end
    rst_n = 1'b1;
    rd_m = 0;
    wr_m = 0;
    @(negedge clk);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_no_resp_after", resp_valid, 0);
    do_req(1'b0, 8'd154, 16'h0, 1'b0);
    @(negedge clk);

    // Random traffic against the reference array.
    for (int n = 0; n < 40; n++) begin
      logic        w;
      logic [7:0]  a;
      logic [15:0] d;
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      d = 16'($urandom);
      do_req(w, a, d, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
    end

    // Load counter saturation from a preloaded near-full value.
    force dut.rd_count_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.rd_count_q;
    rd_m = 16'hFFFE;
    chk("sat_preload", rd_count, 16'hFFFE);
    for (int n = 0; n < 3; n++) begin
      do_req(1'b0, 8'($urandom_range(0, 255)), 16'h0, 1'b0);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("sat_hold", rd_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
